// File: rtl/lct_quality_run3_pipe.sv
// -----------------------------------------------------------------------------
// lct_quality_run3_pipe
//
// Run-3 LCT quality encoder. It sits between the ALCT-CLCT matcher and the MPC
// frame builder. Each LCT channel in a crossing gets a 2-bit quality. The
// quality comes from comparing a hit-count metric against three programmable
// thresholds. The metric is the max (OR mode) or the min (AND mode) of the ALCT
// and CLCT layer counts. The result is registered once, then delayed by
// PIPE_DEPTH more stages, so the fixed latency is 1+PIPE_DEPTH. Each quality
// code has its own saturating event counter, and VME can read the counters
// back.
//
// Ports
//   clock            40 MHz LHC clock
//   global_reset     synchronous, active-high reset
//   lct_vld          per-channel LCT valid strobe
//   alct_found       per-channel ALCT present
//   clct_found       per-channel CLCT present
//   alct_nhit        packed ALCT layer counts, channel 0 in LSBs
//   clct_nhit        packed CLCT layer counts, channel 0 in LSBs
//   thr_q3/q2/q1     minimum metric for Q=3/2/1
//   mode_and         0: metric = max(alct,clct); 1: metric = min
//   cnt_clear        synchronous clear of all counters and saturation flags
//   cnt_sel          quality code whose counter drives cnt_rdata
//   lct_quality      packed quality, channel 0 in LSBs
//   lct_quality_vld  delayed lct_vld, aligned with lct_quality
//   cnt_rdata        registered value of counter[cnt_sel]
//   cnt_sat          per-code sticky saturation flag
// -----------------------------------------------------------------------------
module lct_quality_run3_pipe #(
  parameter int NLCT       = 2,
  parameter int MXHITW     = 3,
  parameter int PIPE_DEPTH = 1,
  parameter int CNTW       = 16
) (
  input  logic                   clock,
  input  logic                   global_reset,
  input  logic [NLCT-1:0]        lct_vld,
  input  logic [NLCT-1:0]        alct_found,
  input  logic [NLCT-1:0]        clct_found,
  input  logic [NLCT*MXHITW-1:0] alct_nhit,
  input  logic [NLCT*MXHITW-1:0] clct_nhit,
  input  logic [MXHITW-1:0]      thr_q3,
  input  logic [MXHITW-1:0]      thr_q2,
  input  logic [MXHITW-1:0]      thr_q1,
  input  logic                   mode_and,
  input  logic                   cnt_clear,
  input  logic [1:0]             cnt_sel,
  output logic [NLCT*2-1:0]      lct_quality,
  output logic [NLCT-1:0]        lct_quality_vld,
  output logic [CNTW-1:0]        cnt_rdata,
  output logic [3:0]             cnt_sat
);

  // Per-clock increment is 0..NLCT, so it needs enough bits to hold NLCT.
  localparam int INCW = $clog2(NLCT + 1);

  // ---------------------------------------------------------------------------
  // Stage 0: combinational quality encode. Thresholds and mode are used only
  // here, so a change affects the next crossing and never data in flight.
  // ---------------------------------------------------------------------------
  logic [NLCT*2-1:0] qual_d;
  logic [NLCT-1:0]   vld_d;
  logic [MXHITW-1:0] a_nhit, c_nhit, metric;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    qual_d = '0;
    vld_d  = '0;
    a_nhit = '0;
    c_nhit = '0;
    metric = '0;
    for (int ch = 0; ch < NLCT; ch++) begin
      a_nhit = alct_nhit[ch*MXHITW +: MXHITW];
      c_nhit = clct_nhit[ch*MXHITW +: MXHITW];
      if (mode_and) metric = (a_nhit < c_nhit) ? a_nhit : c_nhit;
      else          metric = (a_nhit > c_nhit) ? a_nhit : c_nhit;
      vld_d[ch] = lct_vld[ch];
      // The thresholds are not checked for order. The priority chain is applied
      // exactly as written, so inverted thresholds still resolve top-down.
      if (lct_vld[ch] && alct_found[ch] && clct_found[ch]) begin
        if      (metric >= thr_q3) qual_d[ch*2 +: 2] = 2'd3;
        else if (metric >= thr_q2) qual_d[ch*2 +: 2] = 2'd2;
        else if (metric >= thr_q1) qual_d[ch*2 +: 2] = 2'd1;
        else                       qual_d[ch*2 +: 2] = 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quality register (index 0) followed by PIPE_DEPTH delay stages.
  // ---------------------------------------------------------------------------
  logic [PIPE_DEPTH:0][NLCT*2-1:0] qual_q;
  logic [PIPE_DEPTH:0][NLCT-1:0]   vld_q;

  always_ff @(posedge clock) begin
    // NOTE: the whole delay line is reset, not only the valid bits. A reset in
    // mid-stream must leave no stale quality values that could reach the output.
    if (global_reset) begin
      qual_q <= '0;
      vld_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the value its
      // neighbour held before this edge, so the shift order does not matter.
      qual_q[0] <= qual_d;
      vld_q[0]  <= vld_d;
      for (int s = 1; s <= PIPE_DEPTH; s++) begin
        qual_q[s] <= qual_q[s-1];
        vld_q[s]  <= vld_q[s-1];
      end
    end
  end

  assign lct_quality     = qual_q[PIPE_DEPTH];
  assign lct_quality_vld = vld_q[PIPE_DEPTH];

  // ---------------------------------------------------------------------------
  // Per-code event counters, driven from the output stage.
  // ---------------------------------------------------------------------------
  logic [INCW-1:0] inc_d [4];
  logic [CNTW:0]   sum_d [4];
  logic [CNTW-1:0] cnt_d [4];
  logic [3:0]      sat_d;
  logic [CNTW-1:0] cnt_q [4];
  logic [3:0]      sat_q;
  logic [CNTW-1:0] rdata_q;

  always_comb begin
    sat_d = sat_q;
    for (int k = 0; k < 4; k++) begin
      inc_d[k] = '0;
      for (int ch = 0; ch < NLCT; ch++) begin
        if (lct_quality_vld[ch] && (lct_quality[ch*2 +: 2] == 2'(k)))
          inc_d[k] = inc_d[k] + INCW'(1);
      end
      // One guard bit catches overflow. The counter then holds at all-ones
      // and the sticky flag for this code is set.
      sum_d[k] = {1'b0, cnt_q[k]} + (CNTW+1)'(inc_d[k]);
      if (sum_d[k][CNTW]) begin
        cnt_d[k] = '1;
        sat_d[k] = 1'b1;
      end else begin
        cnt_d[k] = sum_d[k][CNTW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset || cnt_clear) begin
      // If a clear arrives in the same cycle as an increment, the clear wins
      // and that cycle's events are dropped.
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      sat_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      sat_q <= sat_d;
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) rdata_q <= '0;
    else              rdata_q <= cnt_q[cnt_sel];
  end

  assign cnt_rdata = rdata_q;
  assign cnt_sat   = sat_q;

endmodule

// File: doc/lct_quality_run3_pipe.md
Name: lct_quality_run3_pipe

Overview:
Pipelined, parametrised Run-3 LCT quality encoder for NLCT LCT channels per bunch crossing (first/second LCT). Each channel gets a 2-bit quality computed against programmable hit-count thresholds, selectable OR/AND combining mode, and a fixed-latency registered output. Per-quality-code saturating event counters are VME-readable. Sits between the ALCT-CLCT matcher and the MPC frame builder.

Parameters:
NLCT, 2, number of LCT channels per crossing (1..4)
MXHITW, 3, width of alct_nhit/clct_nhit and of each threshold
PIPE_DEPTH, 1, extra delay stages after the quality register (0..4); total latency = 1+PIPE_DEPTH
CNTW, 16, width of each quality counter

Ports:
clock  in  1  40 MHz LHC clock
global_reset  in  1  synchronous, active-high reset
lct_vld  in  NLCT  per-channel LCT valid strobe
alct_found  in  NLCT  per-channel ALCT present
clct_found  in  NLCT  per-channel CLCT present
alct_nhit  in  NLCT*MXHITW  packed ALCT layer counts, channel 0 in LSBs
clct_nhit  in  NLCT*MXHITW  packed CLCT layer counts, channel 0 in LSBs
thr_q3  in  MXHITW  minimum metric for Q=3 (VME, default 6)
thr_q2  in  MXHITW  minimum metric for Q=2 (default 5)
thr_q1  in  MXHITW  minimum metric for Q=1 (default 4)
mode_and  in  1  0: metric = max(alct_nhit, clct_nhit); 1: metric = min
cnt_clear  in  1  synchronous clear of all counters
cnt_sel  in  2  selects counter for read-back (quality code 0..3)
lct_quality  out  NLCT*2  packed quality, channel 0 in LSBs
lct_quality_vld  out  NLCT  delayed lct_vld aligned with lct_quality
cnt_rdata  out  CNTW  value of counter cnt_sel
cnt_sat  out  4  per-code sticky saturation flag

Behaviour:
- Clock and reset: single clock; global_reset is synchronous, active-high.
- Per channel, combinational stage 0: if lct_vld & alct_found & clct_found, compute metric (max or min per mode_and). Unsigned compare, priority Q3 > Q2 > Q1: metric>=thr_q3 -> 3; else >=thr_q2 -> 2; else >=thr_q1 -> 1; else 0. If lct_vld is high but either found bit is low -> Q=0. If lct_vld is low -> Q=0 and vld=0.
- Registered at edge 1, then shifted through PIPE_DEPTH stages. Output is valid exactly 1+PIPE_DEPTH clocks after the input. No back-pressure; one new set per clock.
- Threshold ordering is not checked. Inverted thresholds follow priority literally, e.g. thr_q3=2, thr_q2=5 with metric 5 -> Q=3. A threshold of 0 matches any matched LCT.
- Thresholds and mode are sampled in stage 0, so a change takes effect on the next input crossing without glitching in-flight data.
- Counters: 4 counters, one per code. On each output-stage cycle, counter[q] += number of channels with lct_quality_vld=1 and quality q (0..NLCT per clock).
- Counters saturate at all-ones, with no wrap. When an increment would exceed the max, the counter holds at all-ones and cnt_sat[q] sets.
- cnt_sat is sticky until cnt_clear or reset.
- cnt_clear and an increment in the same cycle: clear wins; the counter becomes 0 and that cycle's events are dropped.
- cnt_rdata is registered, showing counter[cnt_sel] one clock after cnt_sel changes.
- Reset: all pipeline stages, lct_quality, lct_quality_vld, counters, cnt_sat and cnt_rdata become 0. A reset mid-stream discards in-flight LCTs, which are never counted. The first valid output appears 1+PIPE_DEPTH clocks after the first post-reset input.

Test Plan:
- Defaults (6/5/4, mode_and=0, PIPE_DEPTH=1), ch0 alct=6 clct=3, ch1 alct=4 clct=5 -> 2 clocks later quality={ch1=2, ch0=3}, vld=2'b11; counter[3]=1, counter[2]=1.
- mode_and=1, ch0 alct=6 clct=4 -> Q=1; alct=3 clct=6 -> Q=0; alct_found=0 with both nhit=6 -> Q=0 but vld=1, counter[0] increments.
- Thresholds changed to 3/2/1 on cycle N while an LCT is in flight -> in-flight LCT keeps old quality; an input at cycle N with metric 3 -> Q=3.
- CNTW=4, NLCT=2, 8 crossings each with 2x Q=3 -> counter[3] saturates at 15, cnt_sat[3]=1. cnt_clear -> 0, flag cleared; clear with a simultaneous Q=3 event -> counter stays 0.
- PIPE_DEPTH=3: single valid pulse -> output exactly 4 clocks later; global_reset asserted 2 clocks after input -> no output, all counters 0.
- Random sweep of nhit 0..7, both modes, vs reference model -> zero mismatches; with 6/5/4 thresholds and mode 0, matches the legacy equality encoding for nhit<=6.
